// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM states, stage bit
// indices and the fixed stall/flush patterns driven onto the pipeline.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_IDLE  = 2'd0,
        PC_DIVW  = 2'd1,
        PC_FLUSH = 2'd2
    } pc_state_e;

    localparam int unsigned STALL_PC    = 0;
    localparam int unsigned STALL_IFID  = 1;
    localparam int unsigned STALL_IDEX  = 2;
    localparam int unsigned STALL_EXMEM = 3;
    localparam int unsigned STALL_MEMWB = 4;
    localparam int unsigned N_STAGE     = 5;

    typedef logic [N_STAGE-1:0] stage_vec_t;

    // Load-use: hold PC and IF/ID, drop one bubble into ID/EX.
    localparam stage_vec_t VEC_HOLD_STALL  = 5'b00011;
    localparam stage_vec_t VEC_HOLD_FLUSH  = 5'b00100;
    // Divide in flight: freeze the front end, bubble behind EX.
    localparam stage_vec_t VEC_DIV_STALL   = 5'b00111;
    localparam stage_vec_t VEC_DIV_FLUSH   = 5'b01000;
    // Redirect squashes the two younger instructions.
    localparam stage_vec_t VEC_REDIR_FLUSH = 5'b00110;
    // Watchdog abort also squashes the dead divide in EX.
    localparam stage_vec_t VEC_WDOG_FLUSH  = 5'b01100;
    localparam stage_vec_t VEC_IFID_FLUSH  = 5'b00010;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Generic watchdog counter: clear has priority over enable; expire is raised
// combinationally on the enabled cycle where the count reaches LIMIT-1.
module pipe_ctrl_wdog #(
    parameter int unsigned CNT_W = 7,
    parameter int unsigned LIMIT = 80
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expire = en && !clr && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush/redirect controller for the 5-stage pipeline:
// IDLE / DIV_WAIT / FLUSH sequencing, divide watchdog and stall statistics.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned DIV_TIMEOUT = 80,
    parameter int unsigned CNT_W       = 7,
    parameter int unsigned FLUSH_CYC   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_hold_i,
    input  logic              ex_div_start_i,
    input  logic              ex_div_done_i,
    input  logic              ex_jump_i,
    input  logic [ADDR_W-1:0] ex_jump_addr_i,
    input  logic              trap_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    output logic [4:0]        stall_o,
    output logic [4:0]        flush_o,
    output logic              jump_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic              div_kill_o,
    output logic              div_timeout_o,
    output logic [31:0]       stall_cnt_o
);

    localparam logic       HAS_FLUSH  = (FLUSH_CYC != 0);
    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYC);

    pc_state_e   state_q, state_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic        timeout_q;
    logic [31:0] stall_cnt_q;

    stage_vec_t        stall_c, flush_c;
    logic              jump_c, kill_c;
    logic [ADDR_W-1:0] addr_c;
    logic              wdog_clr, wdog_en, wdog_expire, timeout_set;
    logic              redirect;
    logic [ADDR_W-1:0] redir_addr;

    assign redirect   = trap_i | ex_jump_i;
    assign redir_addr = trap_i ? trap_addr_i : ex_jump_addr_i;

    pipe_ctrl_wdog #(
        .CNT_W (CNT_W),
        .LIMIT (DIV_TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wdog_clr),
        .en     (wdog_en),
        .expire (wdog_expire)
    );

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        stall_c     = '0;
        flush_c     = '0;
        jump_c      = 1'b0;
        addr_c      = '0;
        kill_c      = 1'b0;
        wdog_clr    = 1'b0;
        wdog_en     = 1'b0;
        timeout_set = 1'b0;

        case (state_q)
            PC_IDLE: begin
                if (redirect) begin
                    jump_c      = 1'b1;
                    addr_c      = redir_addr;
                    flush_c     = VEC_REDIR_FLUSH;
                    state_d     = HAS_FLUSH ? PC_FLUSH : PC_IDLE;
                    flush_cnt_d = FLUSH_INIT;
                end else if (ex_div_start_i) begin
                    stall_c  = VEC_DIV_STALL;
                    flush_c  = VEC_DIV_FLUSH;
                    wdog_clr = 1'b1;
                    state_d  = PC_DIVW;
                end else if (id_hold_i) begin
                    stall_c = VEC_HOLD_STALL;
                    flush_c = VEC_HOLD_FLUSH;
                end
            end

            PC_DIVW: begin
                // EX is owned by the divide: jumps and load-use holds cannot occur here.
                wdog_en = 1'b1;
                if (trap_i) begin
                    kill_c      = 1'b1;
                    jump_c      = 1'b1;
                    addr_c      = trap_addr_i;
                    flush_c     = VEC_REDIR_FLUSH;
                    state_d     = HAS_FLUSH ? PC_FLUSH : PC_IDLE;
                    flush_cnt_d = FLUSH_INIT;
                end else if (ex_div_done_i) begin
                    state_d = PC_IDLE;
                end else if (wdog_expire) begin
                    kill_c      = 1'b1;
                    timeout_set = 1'b1;
                    flush_c     = VEC_WDOG_FLUSH;
                    state_d     = PC_IDLE;
                end else begin
                    stall_c = VEC_DIV_STALL;
                    flush_c = VEC_DIV_FLUSH;
                end
            end

            PC_FLUSH: begin
                flush_c = VEC_IFID_FLUSH;
                if (redirect) begin
                    jump_c      = 1'b1;
                    addr_c      = redir_addr;
                    flush_c     = VEC_REDIR_FLUSH;
                    flush_cnt_d = FLUSH_INIT;
                end else if (flush_cnt_q <= 2'd1) begin
                    state_d = PC_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 2'd1;
                end
            end

            default: state_d = PC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PC_IDLE;
            flush_cnt_q <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
            if (stall_c[STALL_PC]) begin
                stall_cnt_q <= sat_inc32(stall_cnt_q);
            end
        end
    end

    // Combinational outputs are forced quiet while reset is asserted,
    // since IDLE decode would otherwise still follow the inputs.
    assign stall_o       = rst_n ? stall_c : '0;
    assign flush_o       = rst_n ? flush_c : '0;
    assign jump_o        = rst_n & jump_c;
    assign jump_addr_o   = rst_n ? addr_c : '0;
    assign div_kill_o    = rst_n & kill_c;
    assign div_timeout_o = timeout_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares every DUT output.
module tb_pipe_ctrl;

    localparam logic [4:0] Z5   = 5'b00000;
    localparam logic [4:0] HS   = 5'b00011;
    localparam logic [4:0] HF   = 5'b00100;
    localparam logic [4:0] DS   = 5'b00111;
    localparam logic [4:0] DF   = 5'b01000;
    localparam logic [4:0] RF   = 5'b00110;
    localparam logic [4:0] WF   = 5'b01100;
    localparam logic [4:0] FF   = 5'b00010;
    localparam logic [63:0] A0  = 64'h0;
    localparam logic [63:0] JA  = 64'h8000_0040;
    localparam logic [63:0] TA  = 64'h8000_0100;
    localparam logic [63:0] JB  = 64'h8000_2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_hold_i = 1'b0, ex_div_start_i = 1'b0, ex_div_done_i = 1'b0;
    logic        ex_jump_i = 1'b0, trap_i = 1'b0;
    logic [63:0] ex_jump_addr_i = '0, trap_addr_i = '0;
    logic [4:0]  stall_o, flush_o;
    logic        jump_o, div_kill_o, div_timeout_o;
    logic [63:0] jump_addr_o;
    logic [31:0] stall_cnt_o;

    pipe_ctrl #(
        .ADDR_W      (64),
        .DIV_TIMEOUT (80),
        .CNT_W       (7),
        .FLUSH_CYC   (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_hold_i      (id_hold_i),
        .ex_div_start_i (ex_div_start_i),
        .ex_div_done_i  (ex_div_done_i),
        .ex_jump_i      (ex_jump_i),
        .ex_jump_addr_i (ex_jump_addr_i),
        .trap_i         (trap_i),
        .trap_addr_i    (trap_addr_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .jump_o         (jump_o),
        .jump_addr_o    (jump_addr_o),
        .div_kill_o     (div_kill_o),
        .div_timeout_o  (div_timeout_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [4:0]  stall;
        logic [4:0]  flush;
        logic        jump;
        logic [63:0] addr;
        logic        kill;
        logic        to;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    string       cur_tag = "init";
    logic [31:0] m_cnt = '0;
    logic        m_to = 1'b0;

    task automatic drive(input logic h, input logic s, input logic d, input logic j,
                         input logic [63:0] ja, input logic t, input logic [63:0] ta);
        @(posedge clk);
        #1;
        id_hold_i      = h;
        ex_div_start_i = s;
        ex_div_done_i  = d;
        ex_jump_i      = j;
        ex_jump_addr_i = ja;
        trap_i         = t;
        trap_addr_i    = ta;
    endtask

    // Registered outputs seen this cycle reflect only earlier cycles,
    // so the stall-count model advances after the push.
    task automatic expect_out(input logic [4:0] es, input logic [4:0] ef, input logic ej,
                              input logic [63:0] ea, input logic ek);
        exp_t e;
        e.tag = cur_tag; e.stall = es; e.flush = ef; e.jump = ej; e.addr = ea;
        e.kill = ek; e.to = m_to; e.cnt = m_cnt;
        sb.push_back(e);
        if (es[0]) m_cnt = m_cnt + 32'd1;
    endtask

    task automatic step(input logic h, input logic s, input logic d, input logic j,
                        input logic [63:0] ja, input logic t, input logic [63:0] ta,
                        input logic [4:0] es, input logic [4:0] ef, input logic ej,
                        input logic [63:0] ea, input logic ek);
        drive(h, s, d, j, ja, t, ta);
        expect_out(es, ef, ej, ea, ek);
    endtask

    task automatic idle_zero();
        step(0, 0, 0, 0, A0, 0, A0, Z5, Z5, 0, A0, 0);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_chk++;
            if (stall_o === e.stall && flush_o === e.flush && jump_o === e.jump &&
                jump_addr_o === e.addr && div_kill_o === e.kill &&
                div_timeout_o === e.to && stall_cnt_o === e.cnt) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got stall=%b flush=%b jump=%b addr=%h kill=%b to=%b cnt=%0d, want stall=%b flush=%b jump=%b addr=%h kill=%b to=%b cnt=%0d",
                         e.tag, stall_o, flush_o, jump_o, jump_addr_o, div_kill_o, div_timeout_o,
                         stall_cnt_o, e.stall, e.flush, e.jump, e.addr, e.kill, e.to, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        #23;
        rst_n = 1'b1;
        cur_tag = "reset_state";
        idle_zero();

        cur_tag = "load_use";
        step(1, 0, 0, 0, A0, 0, A0, HS, HF, 0, A0, 0);
        cur_tag = "load_use_after";
        idle_zero();

        cur_tag = "div_start";
        step(0, 1, 0, 0, A0, 0, A0, DS, DF, 0, A0, 0);
        for (int i = 1; i <= 32; i++) begin
            cur_tag = (i == 10) ? "div_wait_ignores_jump" : "div_wait";
            step((i == 10), 0, 0, (i == 10), JB, 0, A0, DS, DF, 0, A0, 0);
        end
        cur_tag = "div_done";
        step(0, 0, 1, 0, A0, 0, A0, Z5, Z5, 0, A0, 0);
        cur_tag = "div_back_idle";
        idle_zero();

        cur_tag = "jump_over_hold";
        step(1, 0, 0, 1, JA, 0, A0, Z5, RF, 1, JA, 0);
        cur_tag = "post_jump_flush";
        idle_zero_flush();
        cur_tag = "post_flush_idle";
        idle_zero();

        cur_tag = "trap_over_jump";
        step(0, 1, 0, 1, JB, 1, TA, Z5, RF, 1, TA, 0);
        cur_tag = "flush_redirect";
        step(0, 0, 0, 1, JB, 0, A0, Z5, RF, 1, JB, 0);
        cur_tag = "flush_reloaded";
        idle_zero_flush();
        cur_tag = "flush_done_idle";
        idle_zero();

        cur_tag = "div2_start";
        step(0, 1, 0, 0, A0, 0, A0, DS, DF, 0, A0, 0);
        for (int i = 1; i <= 4; i++) begin
            cur_tag = "div2_wait";
            step(0, 0, 0, 0, A0, 0, A0, DS, DF, 0, A0, 0);
        end
        cur_tag = "trap_kills_div";
        step(0, 0, 1, 0, A0, 1, TA, Z5, RF, 1, TA, 1);
        cur_tag = "trap_then_flush";
        idle_zero_flush();
        cur_tag = "trap_flush_idle";
        idle_zero();

        cur_tag = "div3_start";
        step(0, 1, 0, 0, A0, 0, A0, DS, DF, 0, A0, 0);
        for (int i = 1; i <= 79; i++) begin
            cur_tag = "div3_wait";
            step(0, 0, 0, 0, A0, 0, A0, DS, DF, 0, A0, 0);
        end
        cur_tag = "wdog_abort";
        step(0, 0, 0, 0, A0, 0, A0, Z5, WF, 0, A0, 1);
        m_to = 1'b1;
        cur_tag = "timeout_sticky";
        idle_zero();
        cur_tag = "timeout_sticky2";
        idle_zero();

        cur_tag = "div4_start";
        step(0, 1, 0, 0, A0, 0, A0, DS, DF, 0, A0, 0);
        cur_tag = "div4_wait";
        step(0, 0, 0, 0, A0, 0, A0, DS, DF, 0, A0, 0);
        cur_tag = "reset_mid_div";
        drive(1, 1, 1, 1, JA, 1, TA);
        rst_n = 1'b0;
        m_cnt = '0;
        m_to  = 1'b0;
        expect_out(Z5, Z5, 0, A0, 0);
        cur_tag = "reset_held";
        step(1, 1, 1, 1, JA, 1, TA, Z5, Z5, 0, A0, 0);
        cur_tag = "reset_release";
        drive(0, 0, 0, 0, A0, 0, A0);
        rst_n = 1'b1;
        expect_out(Z5, Z5, 0, A0, 0);
        cur_tag = "post_reset_hold";
        step(1, 0, 0, 0, A0, 0, A0, HS, HF, 0, A0, 0);
        cur_tag = "post_reset_cnt";
        idle_zero();

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    task automatic idle_zero_flush();
        step(0, 0, 0, 0, A0, 0, A0, Z5, FF, 0, A0, 0);
    endtask

endmodule
